// File: rtl/pu_riscv_verilog_pkg.sv
// rtl/pu_riscv_verilog_pkg.sv - shared types and constants for the PMP arbiter and checker
package pu_riscv_verilog_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_S = 2'b01;
  localparam logic [1:0] PRV_H = 2'b10;
  localparam logic [1:0] PRV_M = 2'b11;

  localparam logic [1:0] OFF   = 2'd0;
  localparam logic [1:0] TOR   = 2'd1;
  localparam logic [1:0] NA4   = 2'd2;
  localparam logic [1:0] NAPOT = 2'd3;

  localparam logic [2:0] BYTE  = 3'd0;
  localparam logic [2:0] HWORD = 3'd1;
  localparam logic [2:0] WORD  = 3'd2;
  localparam logic [2:0] DWORD = 3'd3;
  localparam logic [2:0] QWORD = 3'd4;

endpackage

// File: rtl/pu_riscv_pmpchk.sv
// rtl/pu_riscv_pmpchk.sv - combinational PMP check of one access against all entries
module pu_riscv_pmpchk
  import pu_riscv_verilog_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PLEN    = 64,
  parameter int PMP_CNT = 16
) (
  input  logic [7:0]      st_pmpcfg_i  [PMP_CNT],
  input  logic [XLEN-1:0] st_pmpaddr_i [PMP_CNT],
  input  logic [1:0]      st_prv_i,
  input  logic            instruction_i,
  input  logic [PLEN-1:0] adr_i,
  input  logic [2:0]      size_i,
  input  logic            we_i,
  input  logic            req_i,
  output logic            exception_o
);

  localparam int   AW      = PLEN - 2;
  localparam logic HAS_PMP = (PMP_CNT > 0);

  // Regions are word granular, so the access is compared as a first/last word pair.
  logic [AW-1:0]      start_w;
  logic [AW-1:0]      end_w;
  logic [PMP_CNT-1:0] hit_any;
  logic [PMP_CNT-1:0] hit_full;
  logic [PMP_CNT-1:0] unused_rsvd;

  assign start_w = adr_i[PLEN-1:2];
  assign end_w   = AW'((adr_i + (PLEN'(1) << size_i) - PLEN'(1)) >> 2);

  for (genvar i = 0; i < PMP_CNT; i++) begin : g_ent
    logic [AW-1:0] pa;
    logic [AW-1:0] prev;
    logic [AW-1:0] msk;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic          en;

    assign pa  = AW'(st_pmpaddr_i[i]);
    assign msk = pa ^ (pa + AW'(1));

    if (i == 0) begin : g_first
      assign prev = '0;
    end else begin : g_rest
      assign prev = AW'(st_pmpaddr_i[i-1]);
    end

    always_comb begin
      lo = '0;
      hi = '0;
      en = 1'b0;
      case (st_pmpcfg_i[i][4:3])
        TOR: begin
          lo = prev;
          hi = pa - AW'(1);
          en = (pa > prev);
        end
        NA4: begin
          lo = pa;
          hi = pa;
          en = 1'b1;
        end
        NAPOT: begin
          lo = pa & ~msk;
          hi = pa | msk;
          en = 1'b1;
        end
        default: ;
      endcase
    end

    assign hit_any[i]     = en && (start_w <= hi) && (end_w >= lo);
    assign hit_full[i]    = en && (start_w >= lo) && (end_w <= hi);
    assign unused_rsvd[i] = ^st_pmpcfg_i[i][6:5];
  end

  logic sel_any;
  logic sel_full;
  logic sel_l;
  logic sel_x;
  logic sel_w;
  logic sel_r;
  logic perm_ok;
  logic m_mode;

  // Lowest-numbered overlapping entry wins, so scan downwards and let lower indices override.
  always_comb begin
    sel_any  = 1'b0;
    sel_full = 1'b0;
    sel_l    = 1'b0;
    sel_x    = 1'b0;
    sel_w    = 1'b0;
    sel_r    = 1'b0;
    for (int i = PMP_CNT - 1; i >= 0; i--) begin
      if (hit_any[i]) begin
        sel_any  = 1'b1;
        sel_full = hit_full[i];
        sel_l    = st_pmpcfg_i[i][7];
        sel_x    = st_pmpcfg_i[i][2];
        sel_w    = st_pmpcfg_i[i][1];
        sel_r    = st_pmpcfg_i[i][0];
      end
    end
  end

  assign m_mode  = (st_prv_i == PRV_M);
  assign perm_ok = instruction_i ? sel_x : (we_i ? sel_w : sel_r);

  assign exception_o = req_i & ((HAS_PMP & ~m_mode & ~sel_any) |
                                (sel_any & ~sel_full) |
                                (sel_any & sel_full & (sel_l | ~m_mode) & ~perm_ok));

endmodule

// File: rtl/pu_riscv_pmp_arbiter.sv
// rtl/pu_riscv_pmp_arbiter.sv - round-robin sharing of one PMP checker between IF and DM
module pu_riscv_pmp_arbiter
  import pu_riscv_verilog_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PLEN    = 64,
  parameter int PMP_CNT = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [7:0]      st_pmpcfg_i  [PMP_CNT],
  input  logic [XLEN-1:0] st_pmpaddr_i [PMP_CNT],
  input  logic [1:0]      st_prv_i,
  input  logic            cfg_update_i,
  input  logic            if_req_i,
  input  logic [PLEN-1:0] if_adr_i,
  input  logic [2:0]      if_size_i,
  output logic            if_ack_o,
  output logic            if_exception_o,
  input  logic            dm_req_i,
  input  logic [PLEN-1:0] dm_adr_i,
  input  logic [2:0]      dm_size_i,
  input  logic            dm_we_i,
  output logic            dm_ack_o,
  output logic            dm_exception_o,
  output logic            busy_o
);

  arb_state_t      state_q, state_d;
  req_id_t         gnt_q, gnt_d;
  req_id_t         last_q, last_d;
  logic [PLEN-1:0] adr_q, adr_d;
  logic [2:0]      size_q, size_d;
  logic            we_q, we_d;
  logic            instr_q, instr_d;
  logic            result_q, result_d;
  logic            pick_dm;
  logic            chk_exception;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      gnt_q    <= REQ_IF;
      last_q   <= REQ_IF;
      adr_q    <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      instr_q  <= 1'b0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      adr_q    <= adr_d;
      size_q   <= size_d;
      we_q     <= we_d;
      instr_q  <= instr_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    adr_d    = adr_q;
    size_d   = size_q;
    we_d     = we_q;
    instr_d  = instr_q;
    result_d = result_q;
    pick_dm  = dm_req_i & (~if_req_i | (last_q == REQ_IF));
    case (state_q)
      IDLE: begin
        if (if_req_i || dm_req_i) begin
          gnt_d   = pick_dm ? REQ_DM : REQ_IF;
          last_d  = pick_dm ? REQ_DM : REQ_IF;
          adr_d   = pick_dm ? dm_adr_i : if_adr_i;
          size_d  = pick_dm ? dm_size_i : if_size_i;
          we_d    = pick_dm & dm_we_i;
          instr_d = ~pick_dm;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // A CSR write this cycle may have changed the answer; re-evaluate next cycle.
        if (!cfg_update_i) begin
          result_d = chk_exception;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  pu_riscv_pmpchk #(
    .XLEN    (XLEN),
    .PLEN    (PLEN),
    .PMP_CNT (PMP_CNT)
  ) u_pmpchk (
    .st_pmpcfg_i   (st_pmpcfg_i),
    .st_pmpaddr_i  (st_pmpaddr_i),
    .st_prv_i      (st_prv_i),
    .instruction_i (instr_q),
    .adr_i         (adr_q),
    .size_i        (size_q),
    .we_i          (we_q),
    .req_i         (state_q == CHECK),
    .exception_o   (chk_exception)
  );

  assign if_ack_o       = (state_q == RESP) && (gnt_q == REQ_IF);
  assign dm_ack_o       = (state_q == RESP) && (gnt_q == REQ_DM);
  assign if_exception_o = if_ack_o & result_q;
  assign dm_exception_o = dm_ack_o & result_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: doc/pu_riscv_pmp_arbiter.md
PU_RISCV_PMP_ARBITER -- requirements
Module: pu_riscv_pmp_arbiter

Interface
REQ-001 Parameters SHALL be: XLEN, default 64, register width; PLEN, default 64, physical address width; PMP_CNT, default 16, number of PMP entries.
REQ-002 Port clk_i  in  1  clock; all state updates on the rising edge.
REQ-003 Port rst_ni  in  1  reset; asynchronous, active-low.
REQ-004 Ports st_pmpcfg_i  in  PMP_CNT x 8, st_pmpaddr_i  in  PMP_CNT x XLEN, st_prv_i  in  2  SHALL carry the PMP CSR state and the current privilege level.
REQ-005 Port cfg_update_i  in  1  SHALL pulse for one cycle when any pmpcfg or pmpaddr CSR is written.
REQ-006 Instruction-fetch requester ports SHALL be: if_req_i  in  1; if_adr_i  in  PLEN; if_size_i  in  3; if_ack_o  out  1; if_exception_o  out  1.
REQ-007 Data requester ports SHALL be: dm_req_i  in  1; dm_adr_i  in  PLEN; dm_size_i  in  3; dm_we_i  in  1; dm_ack_o  out  1; dm_exception_o  out  1.
REQ-008 Port busy_o  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-009 The block SHALL share one PMP checker between the IF and DM requesters, one check at a time.
REQ-010 FSM states SHALL be IDLE, CHECK and RESP.
REQ-011 In IDLE with at least one req high, the block SHALL grant one requester, latch its address, size, we (0 for IF) and instruction flag (1 for IF, 0 for DM), and go to CHECK.
REQ-012 With both reqs high in IDLE, grant SHALL go to the requester not granted last (round-robin); a single req SHALL be granted immediately.
REQ-013 In CHECK, the checker SHALL evaluate the latched request against the live CSR inputs; the registered result SHALL be stored and the FSM SHALL move to RESP.
REQ-014 If cfg_update_i is high in CHECK, that cycle's result SHALL be discarded and the FSM SHALL stay in CHECK one more cycle.
REQ-015 In RESP, the granted requester's ack SHALL be high for exactly one cycle with its exception output valid; the other requester's ack/exception SHALL be 0; the next state SHALL be IDLE.
REQ-016 Latency: req sampled in IDLE at cycle 0 SHALL produce ack in cycle 2 (cycle 2+k with k cfg_update_i pulses during CHECK).
REQ-017 Requesters SHALL hold req and inputs stable until ack; req still high in the first IDLE cycle after ack SHALL count as a new request.
REQ-018 The exception output SHALL equal the checker result: req AND (no-match in S/U mode with PMP_CNT>0, OR partial match, OR locked/non-M rwx violation).
REQ-019 The exception and ack outputs SHALL be 0 in every state except RESP.
REQ-020 Deassertion of a granted req before ack SHALL NOT abort the check; the ack SHALL still be issued.

Reset
REQ-021 While rst_ni is low: state = IDLE; if_ack_o, dm_ack_o, if_exception_o, dm_exception_o, busy_o = 0; latched request = 0; round-robin pointer = "IF granted last" (DM wins the first tie).
REQ-022 Reset asserted mid-check SHALL drop the in-flight request with no ack after release.

Structure
REQ-023 The FSM state enum and the requester-ID encoding (IF = 0, DM = 1) SHALL live in pu_riscv_verilog_pkg; PRV_M, OFF/TOR/NA4/NAPOT and the transfer sizes SHALL come from the existing packages.
REQ-024 Exactly one pu_riscv_pmpchk instance SHALL be the sole sub-module, with req_i tied high in CHECK only.

Verification
REQ-025 M-mode, all PMPs OFF, IF req at 0x1000 size WORD -> if_ack_o in cycle 2, if_exception_o = 0.
REQ-026 U-mode, all PMPs OFF, DM read 0x2000 -> dm_ack_o in cycle 2, dm_exception_o = 1.
REQ-027 Both reqs high after reset -> DM acked in cycle 2, IF acked in cycle 5; the next tie goes to DM.
REQ-028 U-mode, entry 0 NAPOT 0x8000-0x8FFF R only, DM write 0x8010 -> exception 1; DM read 0x8FFC DWORD -> exception 1 (partial); DM read 0x8FF8 DWORD -> exception 0.
REQ-029 cfg_update_i pulse in CHECK changing entry 0 from R to RW -> ack delayed to cycle 3, write to 0x8010 reports exception 0.
REQ-030 rst_ni low in CHECK -> all outputs 0 at once, no ack after release.
